dmem_stage_wait: RTL and testbench



---
 rtl/dmem_stage_wait.sv | 148 ++++++++++++++
 tb/tb_dmem_stage_wait.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/dmem_stage_wait.sv
// ---- dmem_stage_wait: Y86-64 memory stage with wait states; DMEM_STATS_EN adds access counters ----
// ---- Rev 1.0 ----
`default_nettype none

module dmem_stage_wait #(
  parameter int DATA_W      = 64,
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 0,
  parameter int BYTE_ADDR   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [3:0]        M_icode,
  input  logic [2:0]        M_stat,
  input  logic [DATA_W-1:0] M_valA,
  input  logic [DATA_W-1:0] M_valE,
  input  logic [3:0]        M_dstM,
  input  logic [3:0]        M_dstE,
  output logic [3:0]        m_icode,
  output logic [2:0]        m_stat,
  output logic [DATA_W-1:0] m_valE,
  output logic [DATA_W-1:0] m_valM,
  output logic [3:0]        m_dstM,
  output logic [3:0]        m_dstE,
  output logic              m_stall
`ifdef DMEM_STATS_EN
  ,
  output logic [31:0]       rd_count,
  output logic [31:0]       wr_count,
  output logic [31:0]       stall_count
`endif
);

  localparam int              BYTES    = DATA_W / 8;
  localparam int              OFF_SH   = $clog2(BYTES);
  localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] OFF_MASK = DATA_W'(BYTES - 1);
  localparam logic [DATA_W-1:0] DEPTH_L  = DATA_W'(DEPTH);
  localparam logic [3:0]      WC       = 4'(WAIT_CYCLES);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  logic [DATA_W-1:0] mem_q [DEPTH] = '{default: '0};

  logic [0:0]        state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;

  logic              w_wr_op, w_rd_op, w_active, w_err, w_valid, w_complete;
  logic [DATA_W-1:0] w_addr, w_idx_full;
  logic [IDX_W-1:0]  w_idx;

  assign m_icode = M_icode;
  assign m_valE  = M_valE;
  assign m_dstM  = M_dstM;
  assign m_dstE  = M_dstE;

  assign w_wr_op  = (M_icode == 4'd4) || (M_icode == 4'd8) || (M_icode == 4'd10);
  assign w_rd_op  = (M_icode == 4'd5) || (M_icode == 4'd9) || (M_icode == 4'd11);
  assign w_active = (w_wr_op || w_rd_op) && (M_stat == 3'd1);

  // popq and ret address through the stack pointer carried in valA
  assign w_addr     = ((M_icode == 4'd9) || (M_icode == 4'd11)) ? M_valA : M_valE;
  assign w_idx_full = (BYTE_ADDR != 0) ? (w_addr >> OFF_SH) : w_addr;
  assign w_idx      = w_idx_full[IDX_W-1:0];
  assign w_err      = (w_idx_full >= DEPTH_L) ||
                      ((BYTE_ADDR != 0) && ((w_addr & OFF_MASK) != '0));
  assign w_valid    = w_active && !w_err;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    m_stall    = 1'b0;
    w_complete = 1'b0;
    if (WAIT_CYCLES == 0) begin
      w_complete = w_valid;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (w_valid) begin
            m_stall = 1'b1;
            state_d = S_WAIT;
            cnt_d   = 4'd1;
          end
        end
        default: begin
          if (cnt_q < WC) begin
            m_stall = 1'b1;
            cnt_d   = cnt_q + 4'd1;
          end else begin
            w_complete = w_valid;
            state_d    = S_IDLE;
            cnt_d      = 4'd0;
          end
        end
      endcase
    end
    // reset abandons any in-flight access, including its write
    if (rst) begin
      m_stall    = 1'b0;
      w_complete = 1'b0;
      state_d    = S_IDLE;
      cnt_d      = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_complete && w_wr_op) begin
      mem_q[w_idx] <= M_valA;
    end
  end

  assign m_valM = (w_complete && w_rd_op) ? mem_q[w_idx] : '0;
  assign m_stat = (w_active && w_err) ? 3'd3 : M_stat;

`ifdef DMEM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q, st_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      st_cnt_q <= '0;
    end else begin
      if (w_complete && w_rd_op && (rd_cnt_q != '1)) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (w_complete && w_wr_op && (wr_cnt_q != '1)) wr_cnt_q <= wr_cnt_q + 32'd1;
      if (m_stall && (st_cnt_q != '1))               st_cnt_q <= st_cnt_q + 32'd1;
    end
  end

  assign rd_count    = rd_cnt_q;
  assign wr_count    = wr_cnt_q;
  assign stall_count = st_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_dmem_stage_wait.sv
// ---- tb_dmem_stage_wait: checks two configurations against a per-instruction reference model ----
// ---- Rev 1.0 ----
`default_nettype none

module tb_dmem_stage_wait;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  // instance A: word index, DEPTH 1024, two wait cycles
  logic [3:0]  a_icode_i, a_dstM_i, a_dstE_i, a_icode, a_dstM, a_dstE;
  logic [2:0]  a_stat_i, a_stat;
  logic [63:0] a_valA_i, a_valE_i, a_valE, a_valM;
  logic        a_stall;
  // instance B: byte address, DEPTH 64, no wait cycles
  logic [3:0]  b_icode_i, b_dstM_i, b_dstE_i, b_icode, b_dstM, b_dstE;
  logic [2:0]  b_stat_i, b_stat;
  logic [63:0] b_valA_i, b_valE_i, b_valE, b_valM;
  logic        b_stall;
`ifdef DMEM_STATS_EN
  logic [31:0] a_rdc, a_wrc, a_stc, b_rdc, b_wrc, b_stc;
`endif

  dmem_stage_wait #(.DATA_W(64), .DEPTH(1024), .WAIT_CYCLES(2), .BYTE_ADDR(0)) u_a (
`ifdef DMEM_STATS_EN
    .rd_count(a_rdc), .wr_count(a_wrc), .stall_count(a_stc),
`endif
    .clk(clk), .rst(rst), .M_icode(a_icode_i), .M_stat(a_stat_i), .M_valA(a_valA_i),
    .M_valE(a_valE_i), .M_dstM(a_dstM_i), .M_dstE(a_dstE_i), .m_icode(a_icode),
    .m_stat(a_stat), .m_valE(a_valE), .m_valM(a_valM), .m_dstM(a_dstM),
    .m_dstE(a_dstE), .m_stall(a_stall));

  dmem_stage_wait #(.DATA_W(64), .DEPTH(64), .WAIT_CYCLES(0), .BYTE_ADDR(1)) u_b (
`ifdef DMEM_STATS_EN
    .rd_count(b_rdc), .wr_count(b_wrc), .stall_count(b_stc),
`endif
    .clk(clk), .rst(rst), .M_icode(b_icode_i), .M_stat(b_stat_i), .M_valA(b_valA_i),
    .M_valE(b_valE_i), .M_dstM(b_dstM_i), .M_dstE(b_dstE_i), .m_icode(b_icode),
    .m_stat(b_stat), .m_valE(b_valE), .m_valM(b_valM), .m_dstM(b_dstM),
    .m_dstE(b_dstE), .m_stall(b_stall));

  int checks = 0;
  int errors = 0;
  logic [63:0] mem_a [int];
  logic [63:0] mem_b [int];
  int a_rd = 0, a_wr = 0, a_st = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model_rd(input bit sel, input int idx);
    if (sel) return mem_b.exists(idx) ? mem_b[idx] : 64'd0;
    return mem_a.exists(idx) ? mem_a[idx] : 64'd0;
  endfunction

  // present one instruction to the selected instance and check every cycle until it retires
  task automatic run_instr(input bit sel, input logic [3:0] ic, input logic [2:0] st,
                           input logic [63:0] va, input logic [63:0] ve);
    logic [3:0]  dm, de;
    logic [63:0] addr, idx;
    bit          is_wr, is_rd, active, err;
    int          wc, depth, ncyc;
    dm = 4'($urandom_range(15));
    de = 4'($urandom_range(15));
    a_icode_i = sel ? 4'd1 : ic; a_stat_i = sel ? 3'd1 : st;
    a_valA_i  = va; a_valE_i = ve; a_dstM_i = dm; a_dstE_i = de;
    b_icode_i = sel ? ic : 4'd1; b_stat_i = sel ? st : 3'd1;
    b_valA_i  = va; b_valE_i = ve; b_dstM_i = dm; b_dstE_i = de;
    wc     = sel ? 0 : 2;
    depth  = sel ? 64 : 1024;
    is_wr  = (ic == 4'd4) || (ic == 4'd8) || (ic == 4'd10);
    is_rd  = (ic == 4'd5) || (ic == 4'd9) || (ic == 4'd11);
    addr   = (ic == 4'd9 || ic == 4'd11) ? va : ve;
    idx    = sel ? addr / 8 : addr;
    err    = (idx >= 64'(depth)) || (sel && (addr % 8 != 0));
    active = (is_wr || is_rd) && (st == 3'd1);
    ncyc   = (active && !err) ? wc + 1 : 1;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      chk("stall", 64'(sel ? b_stall : a_stall), 64'(k < ncyc - 1));
      chk("stat", 64'(sel ? b_stat : a_stat), 64'((active && err) ? 3'd3 : st));
      chk("valM", sel ? b_valM : a_valM,
          (k == ncyc - 1 && active && !err && is_rd) ? model_rd(sel, int'(idx)) : 64'd0);
      chk("pass", {40'd0, sel ? b_icode : a_icode, sel ? b_dstM : a_dstM,
                   sel ? b_dstE : a_dstE, 12'd0}, {40'd0, ic, dm, de, 12'd0});
      chk("valE", sel ? b_valE : a_valE, ve);
      if (!sel && k < ncyc - 1) a_st++;
      @(posedge clk); #1;
    end
    if (active && !err) begin
      if (is_wr) begin
        if (sel) mem_b[int'(idx)] = va; else mem_a[int'(idx)] = va;
      end
      if (!sel) begin
        if (is_wr) a_wr++;
        if (is_rd) a_rd++;
      end
    end
  endtask

  initial begin
    logic [3:0]  ic;
    logic [2:0]  st;
    logic [63:0] ad, dt;
    // reset with a live store presented: no stall, no load data, no write
    rst = 1'b1;
    a_icode_i = 4'd4; a_stat_i = 3'd1; a_valA_i = 64'h55; a_valE_i = 64'd3;
    a_dstM_i = 4'd2; a_dstE_i = 4'd6;
    b_icode_i = 4'd5; b_stat_i = 3'd1; b_valA_i = 64'd0; b_valE_i = 64'd8;
    b_dstM_i = 4'd1; b_dstE_i = 4'd15;
    @(negedge clk);
    chk("rst_stall_a", 64'(a_stall), 64'd0);
    chk("rst_valM_b", b_valM, 64'd0);
    chk("rst_pass_a", 64'(a_icode), 64'd4);
    @(posedge clk); #1;
    rst = 1'b0;
`ifdef DMEM_STATS_EN
    chk("rst_rdc", 64'(a_rdc), 64'd0);
`endif
    run_instr(1'b0, 4'd5, 3'd1, 64'd0, 64'd3);          // store under reset dropped

    // byte-addressed, zero wait: store then load, alignment and range errors
    run_instr(1'b1, 4'd4, 3'd1, 64'hAB, 64'd40);
    run_instr(1'b1, 4'd5, 3'd1, 64'd0, 64'd40);
    run_instr(1'b1, 4'd5, 3'd1, 64'd0, 64'h13);
    run_instr(1'b1, 4'd5, 3'd1, 64'd0, 64'h18);
    run_instr(1'b1, 4'd8, 3'd1, 64'h9, 64'd512);

    // word-indexed, two waits: push/pop, out-of-range call, non-AOK ret
    run_instr(1'b0, 4'd10, 3'd1, 64'h1234, 64'd10);
    run_instr(1'b0, 4'd9, 3'd1, 64'd10, 64'd0);
    run_instr(1'b0, 4'd8, 3'd1, 64'h77, 64'd1024);
    run_instr(1'b0, 4'd11, 3'd2, 64'd10, 64'd0);
    run_instr(1'b0, 4'd4, 3'd1, 64'h77, 64'd7);

    // reset in the second cycle of a store abandons it
    a_icode_i = 4'd4; a_stat_i = 3'd1; a_valA_i = 64'hDEAD; a_valE_i = 64'd7;
    @(negedge clk);
    chk("mid_stall1", 64'(a_stall), 64'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_stall", 64'(a_stall), 64'd0);
    chk("mid_rst_valM", a_valM, 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    a_rd = 0; a_wr = 0; a_st = 0;
    run_instr(1'b0, 4'd5, 3'd1, 64'd0, 64'd7);
    run_instr(1'b0, 4'd4, 3'd1, 64'hDEAD, 64'd7);
    run_instr(1'b0, 4'd5, 3'd1, 64'd0, 64'd7);

    for (int n = 0; n < 120; n++) begin
      bit sel;
      sel = (n % 2) == 1;
      ic  = 4'($urandom_range(11));
      st  = ($urandom_range(4) == 0) ? 3'($urandom_range(4, 2)) : 3'd1;
      dt  = {$urandom(), $urandom()};
      if (sel) ad = 64'($urandom_range(71)) * 8 +
                    (($urandom_range(5) == 0) ? 64'($urandom_range(7, 1)) : 64'd0);
      else     ad = ($urandom_range(7) == 0) ? 64'd1024 + 64'($urandom_range(4095))
                                             : 64'($urandom_range(31));
      if (ic == 4'd9 || ic == 4'd11) run_instr(sel, ic, st, ad, dt);
      else                           run_instr(sel, ic, st, dt, ad);
    end

`ifdef DMEM_STATS_EN
    chk("rd_count", 64'(a_rdc), 64'(a_rd));
    chk("wr_count", 64'(a_wrc), 64'(a_wr));
    chk("stall_count", 64'(a_stc), 64'(a_st));
    chk("b_stall_count", 64'(b_stc), 64'd0);
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
